// File: rtl/dexie_store_gate_ctrl_if.sv
// Checker channel of the DExIE store gate: captured-store request (valid/ready)
// followed by a single verdict beat.
interface dexie_store_gate_ctrl_if;
  logic        chk_req_valid;
  logic        chk_req_ready;
  logic [31:0] chk_pc;
  logic [31:0] chk_addr;
  logic [31:0] chk_data;
  logic [1:0]  chk_len;
  logic        chk_resp_valid;
  logic        chk_resp_ok;

  modport master (
    output chk_req_valid, chk_pc, chk_addr, chk_data, chk_len,
    input  chk_req_ready, chk_resp_valid, chk_resp_ok
  );

  modport slave (
    input  chk_req_valid, chk_pc, chk_addr, chk_data, chk_len,
    output chk_req_ready, chk_resp_valid, chk_resp_ok
  );
endinterface

// File: rtl/dexie_store_gate_ctrl.sv
// DExIE store-stall controller: intercepts memory-stage stores, asks an external
// policy checker for a verdict, then releases the store or halts the core.
module dexie_store_gate_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    dexie_df_mem_store,
  input  logic                    dexie_df_mem_stalling,
  input  logic [31:0]             dexie_df_mem_pc,
  input  logic [31:0]             dexie_df_mem_addr,
  input  logic [1:0]              dexie_df_mem_len,
  input  logic [31:0]             dexie_df_mem_storedata,
  output logic                    dexie_df_mem_stallOnStore,
  output logic                    dexie_df_mem_continueStore,
  output logic                    dexie_stall,
  dexie_store_gate_ctrl_if.master chk,
  input  logic                    violation_clear,
  output logic                    violation,
  output logic [1:0]              cause,
  output logic [CNT_W-1:0]        store_count,
  output logic [CNT_W-1:0]        violation_count
);

  localparam int unsigned TMO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TMO_MAX = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT    = 3'd2,
    S_RELEASE = 3'd3,
    S_DRAIN   = 3'd4,
    S_HALT    = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               sos_q, sos_d;
  logic               cont_q, cont_d;
  logic               halt_q, halt_d;
  logic               req_valid_q, req_valid_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic [1:0]         len_q, len_d;
  logic [1:0]         cause_q, cause_d;
  logic [CNT_W-1:0]   store_count_q, store_count_d;
  logic [CNT_W-1:0]   vcount_q, vcount_d;
  logic               timeout_hit;
  logic               enter_halt;

  always_comb begin
    state_d       = state_q;
    tmo_d         = tmo_q;
    req_valid_d   = req_valid_q;
    pc_d          = pc_q;
    addr_d        = addr_q;
    data_d        = data_q;
    len_d         = len_q;
    cause_d       = cause_q;
    store_count_d = store_count_q;
    vcount_d      = vcount_q;
    enter_halt    = 1'b0;
    timeout_hit   = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_W'(TMO_MAX));

    if (state_q == S_REQ || state_q == S_WAIT) begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (enable && sos_q && dexie_df_mem_store && dexie_df_mem_stalling) begin
          state_d     = S_REQ;
          req_valid_d = 1'b1;
          tmo_d       = '0;
          pc_d        = dexie_df_mem_pc;
          addr_d      = dexie_df_mem_addr;
          data_d      = dexie_df_mem_storedata;
          len_d       = dexie_df_mem_len;
        end
      end
      S_REQ: begin
        if (timeout_hit) begin
          state_d     = S_HALT;
          req_valid_d = 1'b0;
          cause_d     = 2'b10;
          enter_halt  = 1'b1;
        end else if (chk.chk_req_ready) begin
          state_d     = S_WAIT;
          req_valid_d = 1'b0;
        end
      end
      S_WAIT: begin
        // A verdict in the expiry cycle still wins over the timeout.
        if (chk.chk_resp_valid && chk.chk_resp_ok) begin
          state_d = S_RELEASE;
          if (store_count_q != '1) store_count_d = store_count_q + CNT_W'(1);
        end else if (chk.chk_resp_valid) begin
          state_d    = S_HALT;
          cause_d    = 2'b01;
          enter_halt = 1'b1;
        end else if (timeout_hit) begin
          state_d    = S_HALT;
          cause_d    = 2'b10;
          enter_halt = 1'b1;
        end
      end
      S_RELEASE: state_d = S_DRAIN;
      S_DRAIN: begin
        // Wait for the released store to leave so it is never captured twice.
        if (!dexie_df_mem_stalling) state_d = S_IDLE;
      end
      S_HALT: begin
        if (violation_clear) begin
          state_d = S_RELEASE;
          cause_d = 2'b00;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_halt && vcount_q != '1) vcount_d = vcount_q + CNT_W'(1);

    sos_d  = enable || (state_d != S_IDLE);
    cont_d = (state_d == S_RELEASE);
    halt_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      tmo_q         <= '0;
      sos_q         <= 1'b0;
      cont_q        <= 1'b0;
      halt_q        <= 1'b0;
      req_valid_q   <= 1'b0;
      pc_q          <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      len_q         <= '0;
      cause_q       <= '0;
      store_count_q <= '0;
      vcount_q      <= '0;
    end else begin
      state_q       <= state_d;
      tmo_q         <= tmo_d;
      sos_q         <= sos_d;
      cont_q        <= cont_d;
      halt_q        <= halt_d;
      req_valid_q   <= req_valid_d;
      pc_q          <= pc_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      len_q         <= len_d;
      cause_q       <= cause_d;
      store_count_q <= store_count_d;
      vcount_q      <= vcount_d;
    end
  end

  assign dexie_df_mem_stallOnStore  = sos_q;
  assign dexie_df_mem_continueStore = cont_q;
  assign dexie_stall                = halt_q;
  assign violation                  = halt_q;
  assign cause                      = cause_q;
  assign store_count                = store_count_q;
  assign violation_count            = vcount_q;
  assign chk.chk_req_valid          = req_valid_q;
  assign chk.chk_pc                 = pc_q;
  assign chk.chk_addr               = addr_q;
  assign chk.chk_data               = data_q;
  assign chk.chk_len                = len_q;

endmodule
